bmu_search_ctrl: RTL

//  Sequencer for the SOM best-matching-unit search. Accepts one distance per neuron over a

---
 rtl/bmu_search_if.sv | 36 +++
 rtl/bmu_search_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bmu_search_if.sv
// Stream, comparator and result signals of the BMU search sequencer.
// slave = the sequencer, master = its surroundings (distance engine, comparator, update stage).
interface bmu_search_if #(
    parameter int DIST_W  = 18,
    parameter int COORD_W = 4
);
    logic               start;
    logic               abort;
    logic               dist_valid;
    logic [DIST_W-1:0]  dist_data;
    logic               dist_ready;
    logic               cmp_en;
    logic [DIST_W-1:0]  cmp_d1;
    logic [COORD_W-1:0] cmp_coord1;
    logic [DIST_W-1:0]  cmp_d2;
    logic [COORD_W-1:0] cmp_coord2;
    logic [DIST_W-1:0]  cmp_win_dist;
    logic [COORD_W-1:0] cmp_win_coord;
    logic               busy;
    logic               done;
    logic [DIST_W-1:0]  bmu_dist;
    logic [COORD_W-1:0] bmu_coord;
    logic               err;

    modport slave (
        input  start, abort, dist_valid, dist_data, cmp_win_dist, cmp_win_coord,
        output dist_ready, cmp_en, cmp_d1, cmp_coord1, cmp_d2, cmp_coord2,
        output busy, done, bmu_dist, bmu_coord, err
    );

    modport master (
        output start, abort, dist_valid, dist_data, cmp_win_dist, cmp_win_coord,
        input  dist_ready, cmp_en, cmp_d1, cmp_coord1, cmp_d2, cmp_coord2,
        input  busy, done, bmu_dist, bmu_coord, err
    );
endinterface

// File: rtl/bmu_search_ctrl.sv
// Best-matching-unit search sequencer driving an external registered min comparator.
// Optional stall timeout enabled with `define BMU_TIMEOUT_EN.
module bmu_search_ctrl #(
    parameter int NUM_NEURONS = 16,
    parameter int DIST_W      = 18,
    parameter int COORD_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    bmu_search_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam logic [COORD_W-1:0] CNT_LAST = COORD_W'(NUM_NEURONS - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [DIST_W-1:0]  bmu_dist_q, bmu_dist_d;
    logic [COORD_W-1:0] bmu_coord_q, bmu_coord_d;
    logic               run;
    logic               hs;

`ifdef BMU_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout;
`endif

    assign run            = (state_q == RUN);
    assign hs             = run & bus.dist_valid;
    assign bus.dist_ready = run;
    assign bus.cmp_en     = hs;
    assign bus.cmp_d1     = bus.dist_data;
    assign bus.cmp_coord1 = cnt_q;
    // First sample is compared against an unbeatable seed so the stale winner never leaks in.
    assign bus.cmp_d2     = (cnt_q == '0) ? '1 : bus.cmp_win_dist;
    assign bus.cmp_coord2 = (cnt_q == '0) ? '0 : bus.cmp_win_coord;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.bmu_dist   = bmu_dist_q;
    assign bus.bmu_coord  = bmu_coord_q;

`ifdef BMU_TIMEOUT_EN
    assign timeout = run && !hs && (stall_q == STALL_W'(TIMEOUT_CYC - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bmu_dist_q  <= '0;
            bmu_coord_q <= '0;
`ifdef BMU_TIMEOUT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bmu_dist_q  <= bmu_dist_d;
            bmu_coord_q <= bmu_coord_d;
`ifdef BMU_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        bmu_dist_d  = bmu_dist_q;
        bmu_coord_d = bmu_coord_q;
`ifdef BMU_TIMEOUT_EN
        stall_d     = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef BMU_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (hs) begin
                    cnt_d = cnt_q + 1'b1;
`ifdef BMU_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (cnt_q == CNT_LAST) begin
                        state_d = SETTLE;
                    end
                end
`ifdef BMU_TIMEOUT_EN
                else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            SETTLE: begin
                // Comparator captured the last sample on the previous edge; its output is final now.
                state_d = IDLE;
                if (!bus.abort) begin
                    bmu_dist_d  = bus.cmp_win_dist;
                    bmu_coord_d = bus.cmp_win_coord;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
